// File: rtl/signal_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : signal_cfg_pkg
// Desc     : Shared constants, field-group word map and state encoding for
//            the signal-generator configuration shadow store.
// Revision : 1.0 - initial release
// ============================================================================
package signal_cfg_pkg;

    localparam int CFG_WIDTH = 832;
    localparam int WORDS     = CFG_WIDTH / 32;

    // Field-group word map shared with software headers and the slicer
    localparam int WORD_FREQ_BASE  = 0;
    localparam int WORD_FREQ_NUM   = 4;
    localparam int WORD_PHASE_BASE = 4;
    localparam int WORD_PHASE_NUM  = 2;
    localparam int WORD_AMP_BASE   = 6;
    localparam int WORD_AMP_NUM    = 2;
    localparam int WORD_RAMP_BASE  = 8;
    localparam int WORD_RAMP_NUM   = 4;
    localparam int WORD_CAL_BASE   = 12;
    localparam int WORD_CAL_NUM    = 8;
    localparam int WORD_CTRL_BASE  = 20;
    localparam int WORD_CTRL_NUM   = 6;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } cfg_state_e;

    function automatic logic word_in_range(input logic [31:0] idx);
        return (idx < 32'(WORDS));
    endfunction

endpackage
`default_nettype wire

// File: rtl/signal_cfg_bank.sv
`default_nettype none
// ============================================================================
// Module   : signal_cfg_bank
// Desc     : Shadow/active configuration register pair with word write port,
//            whole-bank copy strobe and optional registered shadow readback.
// Macro    : SIGNAL_CFG_READBACK_EN - build the shadow readback mux
// Revision : 1.0 - initial release
// ============================================================================
module signal_cfg_bank
    import signal_cfg_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [31:0]          wr_data,
    input  logic                 copy,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [31:0]          rd_data,
    output logic [CFG_WIDTH-1:0] active
);

    logic [CFG_WIDTH-1:0] r_shadow;
    logic [CFG_WIDTH-1:0] r_active;
    logic [CFG_WIDTH-1:0] w_shadow_nxt;
    logic                 w_wr_hit;

    assign w_wr_hit = wr_en && word_in_range(32'(wr_addr));

    // The copy source is the post-write shadow so a same-cycle write is included
    for (genvar k = 0; k < WORDS; k++) begin : g_word
        assign w_shadow_nxt[32*k +: 32] = (w_wr_hit && (wr_addr == ADDR_W'(k)))
                                          ? wr_data : r_shadow[32*k +: 32];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow <= '0;
            r_active <= '0;
        end else begin
            r_shadow <= w_shadow_nxt;
            if (copy) begin
                r_active <= w_shadow_nxt;
            end
        end
    end

    assign active = r_active;

`ifdef SIGNAL_CFG_READBACK_EN
    logic [31:0] w_rd_word;
    logic [31:0] r_rd_data;

    // Out-of-range addresses match no word and read back as zero
    always_comb begin
        w_rd_word = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (rd_addr == ADDR_W'(k)) begin
                w_rd_word = r_shadow[32*k +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_word;
        end
    end

    assign rd_data = r_rd_data;
`else
    logic w_unused_rd_addr;

    assign w_unused_rd_addr = ^rd_addr;
    assign rd_data          = '0;
`endif

endmodule
`default_nettype wire

// File: rtl/signal_cfg_shadow.sv
`default_nettype none
// ============================================================================
// Module   : signal_cfg_shadow
// Desc     : Double-buffered config store; commit_req arms, update_tick copies
//            the shadow bank into the active cfg_data bus in one cycle.
// Macro    : SIGNAL_CFG_READBACK_EN - enable shadow readback on rd_data
// Revision : 1.0 - initial release
// ============================================================================
module signal_cfg_shadow
    import signal_cfg_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [31:0]          wr_data,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [31:0]          rd_data,
    input  logic                 commit_req,
    input  logic                 update_tick,
    output logic                 commit_pending,
    output logic                 commit_done,
    output logic                 wr_err,
    output logic [CNT_W-1:0]     commit_cnt,
    output logic [CFG_WIDTH-1:0] cfg_data
);

    cfg_state_e       r_state;
    cfg_state_e       w_state_nxt;
    logic             w_commit;
    logic             w_accept;
    logic             w_wr_ok;
    logic             w_wr_drop;
    logic             r_commit_q;
    logic             r_commit_done;
    logic             r_wr_err;
    logic [CNT_W-1:0] r_commit_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Writes are only accepted while idle so an armed snapshot stays frozen
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        w_accept    = 1'b0;
        w_wr_ok     = 1'b0;
        w_wr_drop   = 1'b0;
        case (r_state)
            IDLE: begin
                w_wr_ok = wr_en;
                if (commit_req) begin
                    w_accept = 1'b1;
                    if (update_tick) begin
                        w_commit = 1'b1;
                    end else begin
                        w_state_nxt = ARMED;
                    end
                end
            end
            ARMED: begin
                w_wr_drop = wr_en;
                if (update_tick) begin
                    w_commit    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // commit_done trails the active-bank update by one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_commit_q    <= 1'b0;
            r_commit_done <= 1'b0;
            r_commit_cnt  <= '0;
            r_wr_err      <= 1'b0;
        end else begin
            r_commit_q    <= w_commit;
            r_commit_done <= r_commit_q;
            if (w_commit) begin
                r_commit_cnt <= r_commit_cnt + 1'b1;
            end
            if (w_accept) begin
                r_wr_err <= 1'b0;
            end else if (w_wr_drop) begin
                r_wr_err <= 1'b1;
            end
        end
    end

    signal_cfg_bank #(
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_wr_ok),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .copy    (w_commit),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .active  (cfg_data)
    );

    assign commit_pending = (r_state == ARMED);
    assign commit_done    = r_commit_done;
    assign wr_err         = r_wr_err;
    assign commit_cnt     = r_commit_cnt;

endmodule
`default_nettype wire
